// File: rtl/br_pkg.sv
// Shared definitions for the EX-stage branch resolution logic:
// funct3 condition encodings and the redirect FSM state type.
package br_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch bundle: instruction/flag inputs toward the resolver and
// the redirect outputs returned to fetch and the pipeline registers.
interface branch_resolve_unit_if;

    logic        ex_valid;
    logic        ex_branch;
    logic        ex_jump;
    logic [2:0]  ex_funct3;
    logic        Z;
    logic        N;
    logic        V;
    logic        C;
    logic [31:0] ex_target;
    logic        stall;

    logic        pc_src;
    logic [31:0] pc_target;
    logic        flush_d;
    logic        flush_e;
    logic        kill_e;

    modport master (
        output ex_valid, ex_branch, ex_jump, ex_funct3, Z, N, V, C, ex_target, stall,
        input  pc_src, pc_target, flush_d, flush_e, kill_e
    );

    modport slave (
        input  ex_valid, ex_branch, ex_jump, ex_funct3, Z, N, V, C, ex_target, stall,
        output pc_src, pc_target, flush_d, flush_e, kill_e
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition: maps funct3 and the A-B flags to a
// taken decision, flagging the reserved encodings.
module branch_cond
    import br_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    input  logic       C,
    output logic       taken,
    output logic       reserved
);

    always_comb begin
        taken    = 1'b0;
        reserved = 1'b0;
        case (funct3)
            F3_BEQ:  taken = Z;
            F3_BNE:  taken = !Z;
            F3_BLT:  taken = N ^ V;
            F3_BGE:  taken = !(N ^ V);
            // C is the no-borrow carry of A + ~B + 1, so A <u B is !C
            F3_BLTU: taken = !C;
            F3_BGEU: taken = C;
            default: reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: registers a taken decision into a one-cycle
// redirect (predict-not-taken fetch) and keeps saturating perf counters.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_unit_if.slave bus,
    input  logic                 clear_cnt,
    output logic                 bad_branch,
    output logic [CNT_W-1:0]     br_count,
    output logic [CNT_W-1:0]     taken_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

    state_t state;
    state_t state_next;

    logic cond_taken;
    logic cond_reserved;
    logic resolve_p0;
    logic taken_p0;
    logic bad_p0;

    branch_cond u_cond (
        .funct3   (bus.ex_funct3),
        .Z        (bus.Z),
        .N        (bus.N),
        .V        (bus.V),
        .C        (bus.C),
        .taken    (cond_taken),
        .reserved (cond_reserved)
    );

    // Anything in EX while redirecting is wrong-path, so only IDLE resolves.
    assign resolve_p0 = (state == S_IDLE) && bus.ex_valid
                        && (bus.ex_branch || bus.ex_jump) && !bus.stall;
    assign taken_p0   = resolve_p0 && (bus.ex_jump || cond_taken);
    assign bad_p0     = resolve_p0 && !bus.ex_jump && cond_reserved;

    always_comb begin
        state_next  = state;
        bus.pc_src  = 1'b0;
        bus.flush_d = 1'b0;
        bus.flush_e = 1'b0;
        bus.kill_e  = 1'b0;
        case (state)
            S_IDLE: begin
                if (taken_p0) state_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                bus.pc_src  = 1'b1;
                bus.flush_d = 1'b1;
                bus.flush_e = 1'b1;
                bus.kill_e  = 1'b1;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            bus.pc_target <= '0;
            bad_branch    <= 1'b0;
        end else begin
            state      <= state_next;
            bad_branch <= bad_p0;
            if (taken_p0) bus.pc_target <= bus.ex_target;
        end
    end

    // Counter clear outranks a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count    <= '0;
            taken_count <= '0;
        end else if (clear_cnt) begin
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            if (resolve_p0) br_count    <= sat_inc(br_count);
            if (taken_p0)   taken_count <= sat_inc(taken_count);
        end
    end

endmodule
